// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and the sequential divider that sits beside it.
//   div_state_t : divider controller states
//   ALU_WIDTH   : default operand width for both the ALU and the divider
//   FLAG_*      : bit positions of Z/N/C/V inside a packed 4-bit flag word
//   div_flags() : packs divider status bits into that flag word
package alu_pkg;

  localparam int ALU_WIDTH = 4;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  // Z: quotient zero, N: quotient MSB, C: inexact (remainder != 0), V: divide-by-zero
  function automatic logic [3:0] div_flags(input logic q_zero, input logic q_msb,
                                           input logic r_nonzero, input logic div_zero);
    logic [3:0] f;
    f         = '0;
    f[FLAG_Z] = q_zero;
    f[FLAG_N] = q_msb;
    f[FLAG_C] = r_nonzero;
    f[FLAG_V] = div_zero;
    return f;
  endfunction

endpackage

// File: rtl/divider_seq_if.sv
// Handshake/result bundle between the datapath controller and the divider.
//   start      : request pulse (controller -> divider)
//   A, B       : dividend / divisor (controller -> divider)
//   R          : {remainder, quotient} (divider -> controller)
//   busy, done : progress handshake (divider -> controller)
//   Z, N, C, V : result flags (divider -> controller)
// Modports: master = controller side, slave = divider side.
interface divider_seq_if
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
);
  logic               start;
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic [2*WIDTH-1:0] R;
  logic               busy;
  logic               done;
  logic               Z;
  logic               N;
  logic               C;
  logic               V;

  modport master (
    output start, A, B,
    input  R, busy, done, Z, N, C, V
  );

  modport slave (
    input  start, A, B,
    output R, busy, done, Z, N, C, V
  );
endinterface

// File: rtl/divider_seq_div_step.sv
// One combinational restoring-division iteration.
//   rem_in       : current partial remainder (always < divisor, so WIDTH bits suffice)
//   dividend_bit : next dividend bit shifted into the remainder LSB
//   divisor      : divisor
//   rem_out      : partial remainder after the trial subtract (or restore)
//   q_bit        : quotient bit produced by this iteration
// The subtract is a gate-level ripple-borrow chain over the WIDTH+1 bit
// shifted value; the final borrow decides subtract vs. restore.
module div_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             dividend_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   sub;
  logic [WIDTH+1:0] borrow;
  logic [WIDTH-1:0] diff;

  assign shifted   = {rem_in, dividend_bit};
  assign sub       = {1'b0, divisor};
  assign borrow[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 0; gi <= WIDTH; gi++) begin : g_bit
      assign borrow[gi+1] = (~shifted[gi] & sub[gi]) |
                            (~(shifted[gi] ^ sub[gi]) & borrow[gi]);
      // The top difference bit is always 0 when the trial succeeds
      // (result < divisor), so only the borrow is needed there.
      if (gi < WIDTH) begin : g_diff
        assign diff[gi] = shifted[gi] ^ sub[gi] ^ borrow[gi];
      end
    end
  endgenerate

  assign q_bit   = ~borrow[WIDTH+1];
  // On a failed trial the shifted value is < divisor, so its MSB is 0.
  assign rem_out = q_bit ? diff : shifted[WIDTH-1:0];
endmodule

// File: rtl/divider_seq.sv
// Sequential restoring divider, unsigned WIDTH-bit operands, one quotient
// bit per clock.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset (aborts any division in progress)
//   bus : divider_seq_if.slave -- start/A/B in; R/busy/done/Z/N/C/V out
// Flow: IDLE/DONE --start--> LOAD --B!=0--> RUN x WIDTH --> DONE
//                                 --B==0--> DONE (quotient all ones, rem = A)
// R and flags are written on the edge that enters DONE and then held.
module divider_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  divider_seq_if.slave  bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  div_state_t         state_reg, state_next;
  logic [WIDTH-1:0]   div_reg;    // dividend shift reg; quotient fills in from the LSB
  logic [WIDTH-1:0]   b_reg;
  logic [WIDTH-1:0]   rem_reg;
  logic [CW-1:0]      cnt_reg;
  logic [2*WIDTH-1:0] r_reg;
  logic [3:0]         flags_reg;

  logic [WIDTH-1:0]   step_rem;
  logic               step_q;
  logic [WIDTH-1:0]   final_q;
  logic               accept;

  assign accept  = bus.start && ((state_reg == IDLE) || (state_reg == DONE));
  assign final_q = {div_reg[WIDTH-2:0], step_q};

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in       (rem_reg),
    .dividend_bit (div_reg[WIDTH-1]),
    .divisor      (b_reg),
    .rem_out      (step_rem),
    .q_bit        (step_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.start) state_next = LOAD;
      LOAD:    state_next = (b_reg == '0) ? DONE : RUN;
      RUN:     if (cnt_reg == '0) state_next = DONE;
      DONE:    state_next = bus.start ? LOAD : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_reg   <= '0;
      b_reg     <= '0;
      rem_reg   <= '0;
      cnt_reg   <= '0;
      r_reg     <= '0;
      flags_reg <= '0;
    end else begin
      if (accept) begin
        div_reg <= bus.A;
        b_reg   <= bus.B;
      end
      case (state_reg)
        LOAD: begin
          rem_reg <= '0;
          cnt_reg <= CW'(WIDTH - 1);
          if (b_reg == '0) begin
            r_reg     <= {div_reg, {WIDTH{1'b1}}};
            flags_reg <= div_flags(1'b0, 1'b1, |div_reg, 1'b1);
          end
        end
        RUN: begin
          rem_reg <= step_rem;
          div_reg <= final_q;
          cnt_reg <= cnt_reg - CW'(1);
          if (cnt_reg == '0) begin
            r_reg     <= {step_rem, final_q};
            flags_reg <= div_flags(final_q == '0, final_q[WIDTH-1], |step_rem, 1'b0);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.R    = r_reg;
  assign bus.busy = (state_reg == LOAD) || (state_reg == RUN);
  assign bus.done = (state_reg == DONE);
  assign bus.Z    = flags_reg[FLAG_Z];
  assign bus.N    = flags_reg[FLAG_N];
  assign bus.C    = flags_reg[FLAG_C];
  assign bus.V    = flags_reg[FLAG_V];
endmodule

// File: tb/tb_divider_seq.sv
// Directed bench for divider_seq: a vector table of single divisions plus
// hand-written sequences for back-to-back start, start while busy, and
// asynchronous reset during RUN.
module tb_divider_seq;
  logic clk;
  logic rst;

  divider_seq_if #(.WIDTH(4)) bus_if ();

  divider_seq #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] r;
    logic       z, n, c, v;
    int         lat;   // cycles from the start edge to the done cycle, LOAD = cycle 1
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive a start pulse; returns #1 after the accepting edge (LOAD cycle).
  task automatic start_op(input logic [3:0] a, input logic [3:0] b);
    bus_if.A     = a;
    bus_if.B     = b;
    bus_if.start = 1'b1;
    @(posedge clk); #1;
    bus_if.start = 1'b0;
  endtask

  // Step until done, bounded; lat starts at the caller's current cycle index.
  task automatic wait_done(input int lat0, output int lat, output int busy_cnt);
    lat      = lat0;
    busy_cnt = 0;
    while (!bus_if.done && lat < 30) begin
      if (bus_if.busy) busy_cnt++;
      @(posedge clk); #1;
      lat++;
    end
    check("done_seen", bus_if.done, 1);
  endtask

  task automatic check_result(input string tag, input logic [7:0] r,
                              input logic z, input logic n, input logic c, input logic v);
    check({tag, "_R"}, bus_if.R, r);
    check({tag, "_Z"}, bus_if.Z, z);
    check({tag, "_N"}, bus_if.N, n);
    check({tag, "_C"}, bus_if.C, c);
    check({tag, "_V"}, bus_if.V, v);
  endtask

  initial begin
    int lat, bc;

    vecs[0] = '{4'd13, 4'd3,  8'h14, 1'b0, 1'b0, 1'b1, 1'b0, 6};
    vecs[1] = '{4'd7,  4'd0,  8'h7F, 1'b0, 1'b1, 1'b1, 1'b1, 2};
    vecs[2] = '{4'd2,  4'd5,  8'h20, 1'b1, 1'b0, 1'b1, 1'b0, 6};
    vecs[3] = '{4'd15, 4'd1,  8'h0F, 1'b0, 1'b1, 1'b0, 1'b0, 6};
    vecs[4] = '{4'd0,  4'd0,  8'h0F, 1'b0, 1'b1, 1'b0, 1'b1, 2};
    vecs[5] = '{4'd15, 4'd15, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 6};
    vecs[6] = '{4'd8,  4'd3,  8'h22, 1'b0, 1'b0, 1'b1, 1'b0, 6};
    vecs[7] = '{4'd9,  4'd8,  8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 6};

    rst          = 1'b1;
    bus_if.start = 1'b0;
    bus_if.A     = '0;
    bus_if.B     = '0;
    @(posedge clk); #1;
    check("reset_busy", bus_if.busy, 0);
    check("reset_done", bus_if.done, 0);
    check_result("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      start_op(vecs[i].a, vecs[i].b);
      wait_done(1, lat, bc);
      $display("op %0d: %0d / %0d -> R=%02h Z=%b N=%b C=%b V=%b lat=%0d",
               i, vecs[i].a, vecs[i].b, bus_if.R, bus_if.Z, bus_if.N, bus_if.C, bus_if.V, lat);
      check("vec_latency", lat, vecs[i].lat);
      check("vec_busy_cycles", bc, vecs[i].lat - 1);
      check("vec_busy_at_done", bus_if.busy, 0);
      check_result("vec", vecs[i].r, vecs[i].z, vecs[i].n, vecs[i].c, vecs[i].v);
      @(posedge clk); #1;
      check("vec_done_one_cycle", bus_if.done, 0);
      check("vec_R_held", bus_if.R, vecs[i].r);
    end

    // Back-to-back: start held in DONE goes straight to LOAD.
    start_op(4'd15, 4'd1);
    wait_done(1, lat, bc);
    $display("b2b first: 15 / 1 -> R=%02h lat=%0d", bus_if.R, lat);
    check_result("b2b_first", 8'h0F, 1'b0, 1'b1, 1'b0, 1'b0);
    start_op(4'd12, 4'd4);
    check("b2b_no_idle_busy", bus_if.busy, 1);
    check("b2b_no_idle_done", bus_if.done, 0);
    wait_done(1, lat, bc);
    $display("b2b second: 12 / 4 -> R=%02h lat=%0d", bus_if.R, lat);
    check("b2b_latency", lat, 6);
    check_result("b2b_second", 8'h03, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;

    // start re-pulsed with new operands while busy is ignored.
    start_op(4'd13, 4'd3);
    bus_if.A     = 4'd9;
    bus_if.B     = 4'd2;
    bus_if.start = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus_if.start = 1'b0;
    wait_done(3, lat, bc);
    $display("busy restart: 13 / 3 with 9 / 2 mid-run -> R=%02h lat=%0d", bus_if.R, lat);
    check("ignore_latency", lat, 6);
    check_result("ignore", 8'h14, 1'b0, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;
    check("ignore_no_requeue", bus_if.busy, 0);

    // Asynchronous reset between edges during RUN.
    start_op(4'd13, 4'd3);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_reset_busy", bus_if.busy, 1);
    #3 rst = 1'b1;
    #1;
    $display("async reset mid-run -> R=%02h busy=%b done=%b", bus_if.R, bus_if.busy, bus_if.done);
    check("async_rst_busy", bus_if.busy, 0);
    check("async_rst_done", bus_if.done, 0);
    check_result("async_rst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_idle_busy", bus_if.busy, 0);
    check("post_rst_idle_done", bus_if.done, 0);
    check("post_rst_R", bus_if.R, 8'h00);
    start_op(4'd6, 4'd2);
    wait_done(1, lat, bc);
    $display("after reset: 6 / 2 -> R=%02h lat=%0d", bus_if.R, lat);
    check("post_rst_latency", lat, 6);
    check_result("post_rst", 8'h03, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
